// File: rtl/mem_rr_arbiter_pkg.sv
// Shared types and helpers for the round-robin memory-port arbiter.
// The command struct matches the memory port of the 8 x 8-bit memory.
package mem_arb_pkg;

  localparam int ADDR_W = 3;
  localparam int DATA_W = 8;

  typedef struct packed {
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } mem_cmd_t;

  // Width of a requester index; a single requester still needs one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mem_rr_arbiter_rr.sv
// Pure combinational round-robin pick: the first set req bit at or after ptr,
// wrapping modulo NREQ. Returns the one-hot grant, its index and a found flag.
module rr_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]          req,
  input  logic [idx_w(NREQ)-1:0]   ptr,
  output logic [NREQ-1:0]          grant,
  output logic [idx_w(NREQ)-1:0]   idx,
  output logic                     any
);

  localparam int IW = idx_w(NREQ);

  logic [IW-1:0] sel;

  // NOTE: every output gets a default before the search loop, so no path
  // through this block leaves a value unassigned and no latch is inferred.
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    sel   = '0;
    for (int k = 0; k < NREQ; k++) begin
      sel = IW'((int'(ptr) + k) % NREQ);
      if (!any && req[sel]) begin
        any        = 1'b1;
        grant[sel] = 1'b1;
        idx        = sel;
      end
    end
  end

endmodule

// File: rtl/mem_rr_arbiter.sv
// Shares one memory port among NREQ requesters with round-robin fairness,
// registers the winning command onto the port and routes read data back.
module mem_rr_arbiter
  import mem_arb_pkg::mem_cmd_t;
  import mem_arb_pkg::idx_w;
#(
  parameter int NREQ   = 4,
  parameter int ADDR_W = 3,
  parameter int DATA_W = 8,
  parameter int RD_LAT = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ-1:0]          req_wr,
  input  logic [NREQ*ADDR_W-1:0]   req_addr,
  input  logic [NREQ*DATA_W-1:0]   req_wdata,
  output logic [NREQ-1:0]          req_ready,
  output logic [NREQ-1:0]          rsp_valid,
  output logic [DATA_W-1:0]        rsp_rdata,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic                     mem_wr_en,
  output logic                     mem_rd_en,
  output logic [DATA_W-1:0]        mem_wdata,
  input  logic [DATA_W-1:0]        mem_rdata
);

  localparam int IW = idx_w(NREQ);
  typedef logic [IW-1:0] req_idx_t;

  req_idx_t        rr_ptr;
  req_idx_t        win_idx;
  req_idx_t        next_ptr;
  logic [NREQ-1:0] grant;
  logic            win_any;
  mem_cmd_t        win_cmd;

  // Stage 0 mirrors the read being presented on the memory port; stage
  // RD_LAT lines up with mem_rdata.
  logic [RD_LAT:0] rd_vld;
  req_idx_t        rd_tag [RD_LAT+1];

  rr_arbiter #(.NREQ(NREQ)) u_pick (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .grant (grant),
    .idx   (win_idx),
    .any   (win_any)
  );

  assign req_ready = reset ? grant : '0;
  assign next_ptr  = (int'(win_idx) == NREQ - 1) ? '0 : win_idx + 1'b1;

  assign win_cmd = '{wr:    req_wr[win_idx],
                     addr:  req_addr[win_idx*ADDR_W +: ADDR_W],
                     wdata: req_wdata[win_idx*DATA_W +: DATA_W]};

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the values from before the edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rr_ptr    <= '0;
      mem_wr_en <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rd_vld    <= '0;
    end else begin
      mem_wr_en <= win_any && win_cmd.wr;
      rd_vld    <= {rd_vld[RD_LAT-1:0], win_any && !win_cmd.wr};
      if (win_any) begin
        rr_ptr    <= next_ptr;
        mem_addr  <= win_cmd.addr;
        mem_wdata <= win_cmd.wdata;
      end
    end
  end

  // NOTE: tags carry no reset; they are only looked at when the matching
  // valid bit is set, and those valid bits are cleared by reset.
  always_ff @(posedge clk) begin
    rd_tag[0] <= win_idx;
    for (int i = 1; i <= RD_LAT; i++) rd_tag[i] <= rd_tag[i-1];
  end

  assign mem_rd_en = rd_vld[0];

  always_comb begin
    rsp_valid = '0;
    if (rd_vld[RD_LAT]) rsp_valid[rd_tag[RD_LAT]] = 1'b1;
  end

  // Gated so the shared data bus reads 0 whenever no response is due.
  assign rsp_rdata = rd_vld[RD_LAT] ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_rr_arbiter.sv
// Directed bench for mem_rr_arbiter with a write-first 8x8 memory, RD_LAT=1.
module tb_mem_rr_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req_valid;
  logic [3:0]  req_wr;
  logic [11:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_ready;
  logic [3:0]  rsp_valid;
  logic [7:0]  rsp_rdata;
  logic [2:0]  mem_addr;
  logic        mem_wr_en;
  logic        mem_rd_en;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] mem [8] = '{8'h11, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h77};

  always #5 clk = ~clk;

  mem_rr_arbiter #(.NREQ(4), .ADDR_W(3), .DATA_W(8), .RD_LAT(1)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_wr    (req_wr),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .mem_addr  (mem_addr),
    .mem_wr_en (mem_wr_en),
    .mem_rd_en (mem_rd_en),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  // Write-first memory with one cycle of read latency.
  always @(posedge clk) begin
    if (mem_wr_en) mem[mem_addr] <= mem_wdata;
    if (mem_rd_en) mem_rdata <= (mem_wr_en) ? mem_wdata : mem[mem_addr];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic wr,
                         input logic [2:0] a, input logic [7:0] d);
    req_valid[i]         = v;
    req_wr[i]            = wr;
    req_addr[i*3 +: 3]   = a;
    req_wdata[i*8 +: 8]  = d;
  endtask

  initial begin
    reset     = 1'b0;
    req_valid = '0;
    req_wr    = '0;
    req_addr  = '0;
    req_wdata = '0;

    // Reset state, and grants suppressed while reset is low.
    tick();
    tick();
    req_valid = 4'b1111;
    #1;
    check("ready_in_reset", req_ready, 4'b0000);
    req_valid = '0;
    check("rst_wr_en", mem_wr_en, 1'b0);
    check("rst_rd_en", mem_rd_en, 1'b0);
    check("rst_addr", mem_addr, 3'd0);
    check("rst_wdata", mem_wdata, 8'd0);
    check("rst_rsp_valid", rsp_valid, 4'b0000);
    check("rst_rsp_rdata", rsp_rdata, 8'd0);

    // Reset mid-read: the read on the port when reset hits must never respond.
    reset = 1'b1;
    tick();
    set_req(0, 1'b1, 1'b0, 3'd5, 8'h00);
    #1;
    check("mid_ready", req_ready, 4'b0001);
    tick();
    req_valid = '0;
    check("mid_rd_en", mem_rd_en, 1'b1);
    check("mid_addr", mem_addr, 3'd5);
    reset = 1'b0;
    tick();
    check("mid_post_rsp", rsp_valid, 4'b0000);
    check("mid_post_rdata", rsp_rdata, 8'd0);
    check("mid_post_rd_en", mem_rd_en, 1'b0);
    check("mid_post_addr", mem_addr, 3'd0);
    check("mid_post_ready", req_ready, 4'b0000);
    reset = 1'b1;
    tick();
    check("mid_no_rsp1", rsp_valid, 4'b0000);
    tick();
    check("mid_no_rsp2", rsp_valid, 4'b0000);

    // Single write then read from requester 1 (pointer is back at 0).
    set_req(1, 1'b1, 1'b1, 3'd3, 8'hA5);
    #1;
    check("wr_ready", req_ready, 4'b0010);
    tick();
    check("wr_en", mem_wr_en, 1'b1);
    check("wr_rd_en", mem_rd_en, 1'b0);
    check("wr_addr", mem_addr, 3'd3);
    check("wr_wdata", mem_wdata, 8'hA5);
    set_req(1, 1'b1, 1'b0, 3'd3, 8'h00);
    #1;
    check("rd_ready", req_ready, 4'b0010);
    tick();
    req_valid = '0;
    check("rd_en", mem_rd_en, 1'b1);
    check("rd_wr_en", mem_wr_en, 1'b0);
    check("rd_addr", mem_addr, 3'd3);
    tick();
    check("rd_rsp_valid", rsp_valid, 4'b0010);
    check("rd_rsp_rdata", rsp_rdata, 8'hA5);
    tick();
    check("rd_rsp_pulse", rsp_valid, 4'b0000);

    // Pointer wrap: pointer is at 2; grant 3, then 0 ahead of 2.
    set_req(3, 1'b1, 1'b1, 3'd6, 8'h33);
    #1;
    check("wrap_r3", req_ready, 4'b1000);
    tick();
    req_valid = '0;
    set_req(0, 1'b1, 1'b1, 3'd6, 8'h30);
    set_req(2, 1'b1, 1'b1, 3'd6, 8'h32);
    #1;
    check("wrap_first", req_ready, 4'b0001);
    tick();
    check("wrap_wdata0", mem_wdata, 8'h30);
    req_valid[0] = 1'b0;
    #1;
    check("wrap_second", req_ready, 4'b0100);
    tick();
    check("wrap_wdata2", mem_wdata, 8'h32);
    req_valid = '0;
    set_req(3, 1'b1, 1'b1, 3'd6, 8'h33);
    #1;
    check("wrap_r3_again", req_ready, 4'b1000);
    tick();

    // Full contention, pointer now at 0: strict 0,1,2,3 rotation.
    for (int i = 0; i < 4; i++) set_req(i, 1'b1, 1'b1, 3'(i + 1), 8'(8'h40 + i));
    for (int c = 0; c < 8; c++) begin
      #1;
      check($sformatf("cont_ready_%0d", c), req_ready, 32'(4'b0001 << (c % 4)));
      tick();
      check($sformatf("cont_addr_%0d", c), mem_addr, 32'((c % 4) + 1));
    end

    // Idle gap: nothing issued, pointer stays at 0.
    req_valid = '0;
    for (int c = 0; c < 3; c++) begin
      #1;
      check($sformatf("idle_ready_%0d", c), req_ready, 4'b0000);
      tick();
      check($sformatf("idle_cmd_%0d", c), {mem_wr_en, mem_rd_en}, 2'b00);
    end

    // Back-to-back reads from requesters 0 and 2 against preloaded data.
    set_req(0, 1'b1, 1'b0, 3'd0, 8'h00);
    set_req(2, 1'b1, 1'b0, 3'd7, 8'h00);
    #1;
    check("b2b_ready0", req_ready, 4'b0001);
    tick();
    req_valid[0] = 1'b0;
    check("b2b_addr0", mem_addr, 3'd0);
    #1;
    check("b2b_ready2", req_ready, 4'b0100);
    tick();
    req_valid = '0;
    check("b2b_rd_en2", mem_rd_en, 1'b1);
    check("b2b_addr2", mem_addr, 3'd7);
    check("b2b_rsp0", rsp_valid, 4'b0001);
    check("b2b_rdata0", rsp_rdata, 8'h11);
    tick();
    check("b2b_rsp2", rsp_valid, 4'b0100);
    check("b2b_rdata2", rsp_rdata, 8'h77);
    tick();
    check("b2b_rsp_end", rsp_valid, 4'b0000);
    check("b2b_rdata_end", rsp_rdata, 8'h00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
